// File: rtl/memcopy_sequencer_pkg.sv
// Shared definitions for the MEMCOPY micro-sequencer: state encoding,
// decode opcode and the micro-instruction ROM window it occupies.
package memcopy_sequencer_pkg;

  localparam int unsigned STATE_W = 2;

  // Sequencer state enumeration (2-bit, fixed encoding seen on micro_addr)
  typedef logic [STATE_W-1:0] mc_state_t;

  localparam mc_state_t ST_IDLE   = 2'd0;
  localparam mc_state_t ST_RD_REQ = 2'd1;
  localparam mc_state_t ST_WR_REQ = 2'd2;
  localparam mc_state_t ST_DONE   = 2'd3;

  // Decode opcode that launches the sequencer
  localparam logic [7:0] MEMCOPY_OPCODE = 8'h4D;

  // First micro-ROM word reserved for the sequencer states
  localparam logic [5:0] MC_UADDR_BASE = 6'd32;

  // Micro-ROM address for a given active state
  function automatic logic [5:0] mc_uaddr(input mc_state_t s);
    return MC_UADDR_BASE + 6'(s);
  endfunction

endpackage

// File: rtl/memcopy_sequencer.sv
// MEMCOPY sequencer: copies `length` words from src_addr to dst_addr, one
// read followed by one write per word, in ascending address order.
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   start, src_addr,
//   dst_addr, length         launch pulse and transfer descriptor
//   busy, stall, done        status; stall mirrors busy, done is a pulse
//   micro_addr               micro-ROM address (base + state while busy)
//   mem_addr, mem_rd, mem_wr,
//   mem_wdata, mem_rdata,
//   mem_ready                data-memory request port, held until ready
module memcopy_sequencer
  import memcopy_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              stall,
  output logic              done,
  output logic [5:0]        micro_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int unsigned STEP = DATA_W / 8;

  mc_state_t         state_q, state_nxt;
  logic [ADDR_W-1:0] src_q, src_nxt;
  logic [ADDR_W-1:0] dst_q, dst_nxt;
  logic [LEN_W-1:0]  cnt_q, cnt_nxt;
  logic [DATA_W-1:0] data_q, data_nxt;

  logic              busy_nxt;
  logic              done_nxt;
  logic [5:0]        micro_addr_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic              mem_rd_nxt;
  logic              mem_wr_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt;

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      micro_addr <= '0;
      mem_addr   <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_wdata  <= '0;
    end else begin
      state_q    <= state_nxt;
      src_q      <= src_nxt;
      dst_q      <= dst_nxt;
      cnt_q      <= cnt_nxt;
      data_q     <= data_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      micro_addr <= micro_addr_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_rd     <= mem_rd_nxt;
      mem_wr     <= mem_wr_nxt;
      mem_wdata  <= mem_wdata_nxt;
    end
  end

  // Next state / datapath; outputs are decoded from the next state so that
  // they are registered yet line up with the state they describe.
  always_comb begin
    state_nxt = state_q;
    src_nxt   = src_q;
    dst_nxt   = dst_q;
    cnt_nxt   = cnt_q;
    data_nxt  = data_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          src_nxt   = src_addr;
          dst_nxt   = dst_addr;
          cnt_nxt   = length;
          state_nxt = (length == '0) ? ST_DONE : ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        if (mem_ready) begin
          data_nxt  = mem_rdata;
          state_nxt = ST_WR_REQ;
        end
      end
      ST_WR_REQ: begin
        if (mem_ready) begin
          // Address arithmetic wraps silently at the top of the space
          src_nxt   = src_q + ADDR_W'(STEP);
          dst_nxt   = dst_q + ADDR_W'(STEP);
          cnt_nxt   = cnt_q - LEN_W'(1);
          state_nxt = (cnt_q == LEN_W'(1)) ? ST_DONE : ST_RD_REQ;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    busy_nxt       = (state_nxt != ST_IDLE);
    done_nxt       = (state_nxt == ST_DONE);
    mem_rd_nxt     = (state_nxt == ST_RD_REQ);
    mem_wr_nxt     = (state_nxt == ST_WR_REQ);
    micro_addr_nxt = busy_nxt ? mc_uaddr(state_nxt) : 6'd0;
    mem_addr_nxt   = '0;
    mem_wdata_nxt  = '0;
    if (mem_rd_nxt) begin
      mem_addr_nxt = src_nxt;
    end else if (mem_wr_nxt) begin
      mem_addr_nxt  = dst_nxt;
      mem_wdata_nxt = data_nxt;
    end
  end

  assign stall = busy;

endmodule

// File: tb/tb_memcopy_sequencer.sv
// Bench for memcopy_sequencer: memory responder with random/scripted ready,
// transaction-level reference model, per-cycle output comparison.
module tb_memcopy_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] length;
  logic        busy;
  logic        stall;
  logic        done;
  logic [5:0]  micro_addr;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  memcopy_sequencer #(.ADDR_W(32), .DATA_W(32), .LEN_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .busy(busy), .stall(stall), .done(done), .micro_addr(micro_addr),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  int total = 0;
  int bad   = 0;
  int busy_cnt = 0;
  int ready_mode = 0;   // 0: always ready, 1: random, 2: 3 wait cycles per request
  int low_cnt = 0;

  req_t m_q[$];         // outstanding requests the model still expects
  bit   m_busy = 1'b0;
  bit   m_done = 1'b0;
  req_t log_q[$];       // requests the DUT actually completed

  function automatic logic [31:0] fdata(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // Memory responder: ready pattern, read data, log of completed requests
  always @(negedge clk) begin
    bit r;
    r = 1'b1;
    case (ready_mode)
      1: r = ($urandom % 3) != 0;
      2: begin
        if (mem_rd || mem_wr) begin
          if (low_cnt < 3) begin
            r = 1'b0;
            low_cnt++;
          end else begin
            r = 1'b1;
            low_cnt = 0;
          end
        end else begin
          r = 1'($urandom % 2);
        end
      end
      default: r = 1'b1;
    endcase
    mem_ready = r;
    mem_rdata = r ? fdata(mem_addr) : $urandom;
    if (r && (mem_rd || mem_wr))
      log_q.push_back('{wr: mem_wr, addr: mem_addr, data: mem_wdata});
  end

  // Reference model step at each edge, then full output comparison
  always @(posedge clk) begin
    bit   valid;
    bit   e_rd;
    bit   e_wr;
    logic [5:0] e_micro;
    if (!rst_n) begin
      m_q.delete();
      m_busy = 1'b0;
      m_done = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
      m_busy = 1'b0;
    end else if (m_busy) begin
      if (mem_ready) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_done = 1'b1;
      end
    end else if (start) begin
      for (int i = 0; i < int'(length); i++) begin
        logic [31:0] a;
        a = src_addr + 32'(4 * i);
        m_q.push_back('{wr: 1'b0, addr: a, data: 32'h0});
        m_q.push_back('{wr: 1'b1, addr: dst_addr + 32'(4 * i), data: fdata(a)});
      end
      m_busy = 1'b1;
      m_done = (length == 16'd0);
    end
    #2;
    valid   = m_busy && !m_done && (m_q.size() > 0);
    e_rd    = valid && !m_q[0].wr;
    e_wr    = valid && m_q[0].wr;
    e_micro = !m_busy ? 6'd0 : m_done ? 6'd35 : e_rd ? 6'd33 : 6'd34;
    check("busy",       32'(busy),       32'(m_busy));
    check("stall",      32'(stall),      32'(m_busy));
    check("done",       32'(done),       32'(m_done));
    check("mem_rd",     32'(mem_rd),     32'(e_rd));
    check("mem_wr",     32'(mem_wr),     32'(e_wr));
    check("micro_addr", 32'(micro_addr), 32'(e_micro));
    if (valid) check("mem_addr", mem_addr, m_q[0].addr);
    if (e_wr)  check("mem_wdata", mem_wdata, m_q[0].data);
    if (busy === 1'b1) busy_cnt++;
  end

  // Pulse start in an IDLE cycle; returns at the negedge of cycle 1
  task automatic issue(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    @(negedge clk);
    start    = 1'b1;
    src_addr = s;
    dst_addr = d;
    length   = n;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Wait for done; k is the cycle (start acceptance = 0) where done is seen
  task automatic wait_done(input bit noise, output int k);
    k = 1;
    while (done !== 1'b1 && k < 400) begin
      start = noise ? 1'($urandom % 2) : 1'b0;
      src_addr = $urandom;
      dst_addr = $urandom;
      length   = 16'($urandom);
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    if (done !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL wait_done: got no done required done within 400 cycles");
    end
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    start = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    length = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",  32'(busy),       32'd0);
    check("rst_micro", 32'(micro_addr), 32'd0);
    check("rst_addr",  mem_addr,        32'd0);
    rst_n = 1'b1;

    // Basic three-word copy with memory always ready
    ready_mode = 0;
    log_q.delete();
    issue(32'h100, 32'h200, 16'd3);
    wait_done(1'b0, k);
    check("t1_latency", 32'(k), 32'd7);
    check("t1_count", 32'(log_q.size()), 32'd6);
    if (log_q.size() == 6) begin
      for (int i = 0; i < 3; i++) begin
        check("t1_rd_op",   32'(log_q[2*i].wr),   32'd0);
        check("t1_rd_addr", log_q[2*i].addr,      32'h100 + 32'(4 * i));
        check("t1_wr_op",   32'(log_q[2*i+1].wr), 32'd1);
        check("t1_wr_addr", log_q[2*i+1].addr,    32'h200 + 32'(4 * i));
        check("t1_wr_data", log_q[2*i+1].data,    fdata(32'h100 + 32'(4 * i)));
      end
    end

    // Zero-length transfer
    log_q.delete();
    busy_cnt = 0;
    issue(32'h10, 32'h20, 16'd0);
    wait_done(1'b0, k);
    check("t2_latency", 32'(k), 32'd1);
    @(negedge clk);
    check("t2_count", 32'(log_q.size()), 32'd0);
    check("t2_busy_cycles", 32'(busy_cnt), 32'd1);

    // One word with three wait cycles on each request
    ready_mode = 2;
    low_cnt = 0;
    log_q.delete();
    issue(32'h300, 32'h400, 16'd1);
    wait_done(1'b0, k);
    check("t3_latency", 32'(k), 32'd9);
    check("t3_count", 32'(log_q.size()), 32'd2);
    if (log_q.size() == 2) begin
      check("t3_rd_addr", log_q[0].addr, 32'h300);
      check("t3_wr_addr", log_q[1].addr, 32'h400);
      check("t3_wr_data", log_q[1].data, fdata(32'h300));
    end

    // Source address wraps past the top of the space
    ready_mode = 0;
    log_q.delete();
    issue(32'hFFFF_FFFC, 32'h500, 16'd2);
    wait_done(1'b0, k);
    check("t4_latency", 32'(k), 32'd5);
    if (log_q.size() == 4) begin
      check("t4_rd0_addr", log_q[0].addr, 32'hFFFF_FFFC);
      check("t4_rd1_addr", log_q[2].addr, 32'h0000_0000);
      check("t4_wr1_addr", log_q[3].addr, 32'h504);
      check("t4_wr1_data", log_q[3].data, fdata(32'h0));
    end else begin
      check("t4_count", 32'(log_q.size()), 32'd4);
    end

    // Stray start pulses during a transfer are ignored
    log_q.delete();
    issue(32'h40, 32'h80, 16'd3);
    wait_done(1'b1, k);
    check("t5_latency", 32'(k), 32'd7);
    check("t5_count", 32'(log_q.size()), 32'd6);
    if (log_q.size() == 6) begin
      check("t5_rd2_addr", log_q[4].addr, 32'h48);
      check("t5_wr2_addr", log_q[5].addr, 32'h88);
    end

    // Reset during the write of the second of four words
    log_q.delete();
    issue(32'h600, 32'h700, 16'd4);
    repeat (3) @(negedge clk);
    check("t6_in_wr",   32'(mem_wr), 32'd1);
    check("t6_wr_addr", mem_addr,    32'h704);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_busy",  32'(busy),       32'd0);
    check("t6_done",  32'(done),       32'd0);
    check("t6_rd",    32'(mem_rd),     32'd0);
    check("t6_wr",    32'(mem_wr),     32'd0);
    check("t6_addr",  mem_addr,        32'd0);
    check("t6_wdata", mem_wdata,       32'd0);
    check("t6_micro", 32'(micro_addr), 32'd0);
    rst_n = 1'b1;
    log_q.delete();
    issue(32'h800, 32'h900, 16'd2);
    wait_done(1'b0, k);
    check("t6_restart_latency", 32'(k), 32'd5);
    if (log_q.size() == 4) check("t6_restart_wr1", log_q[3].addr, 32'h904);
    else check("t6_restart_count", 32'(log_q.size()), 32'd4);

    // Randomised transfers, model-checked every cycle
    for (int t = 0; t < 40; t++) begin
      int n;
      bit fast;
      n = $urandom_range(0, 6);
      fast = ($urandom % 4) == 0;
      ready_mode = fast ? 0 : 1;
      log_q.delete();
      issue($urandom, $urandom, 16'(n));
      wait_done(1'($urandom % 2), k);
      check("rand_count", 32'(log_q.size()), 32'(2 * n));
      if (fast) check("rand_latency", 32'(k), 32'(2 * n + 1));
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memcopy_sequencer.md
MEMCOPY_SEQUENCER -- requirements
Module: memcopy_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32: word width; addresses step by DATA_W/8.
REQ-003 SHALL have parameter LEN_W, default 16: word-count width.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port start  input  1  one-cycle pulse from decode when MEMCOPY is issued.
REQ-007 SHALL have ports src_addr / dst_addr  input  ADDR_W  source and destination base addresses, sampled on accepted start.
REQ-008 SHALL have port length  input  LEN_W  word count, sampled on accepted start.
REQ-009 SHALL have port busy  output  1  high from the cycle after an accepted start until DONE is left.
REQ-010 SHALL have port stall  output  1  equals busy; freezes PC and fetch.
REQ-011 SHALL have port done  output  1  one-cycle pulse at completion.
REQ-012 SHALL have port micro_addr  output  6  micro-instruction memory address: 32 + state encoding while busy, 0 when idle.
REQ-013 SHALL have ports mem_addr (output, ADDR_W), mem_rd / mem_wr (output, 1), mem_wdata (output, DATA_W), mem_rdata (input, DATA_W), mem_ready (input, 1): data-memory request port.

Function
REQ-014 SHALL implement states IDLE, RD_REQ, WR_REQ, DONE.
REQ-015 IDLE: start accepted only here; latch src, dst, length into src_q, dst_q, cnt_q; go to DONE if length==0, else RD_REQ.
REQ-016 RD_REQ: drive mem_rd=1, mem_addr=src_q, held stable until mem_ready=1. On that cycle capture mem_rdata into data_q and go to WR_REQ.
REQ-017 WR_REQ: drive mem_wr=1, mem_addr=dst_q, mem_wdata=data_q, held stable until mem_ready=1. On that cycle add DATA_W/8 to src_q and dst_q, decrement cnt_q, and go to DONE if cnt_q was 1, else RD_REQ.
REQ-018 DONE: assert done for exactly one cycle, then go to IDLE; busy stays high during DONE.
REQ-019 mem_rd and mem_wr SHALL never be high in the same cycle; both SHALL be 0 outside RD_REQ/WR_REQ.
REQ-020 Address increments SHALL wrap modulo 2^ADDR_W with no error.
REQ-021 start while not IDLE SHALL be ignored, with no effect on the transfer in progress.
REQ-022 mem_ready outside RD_REQ/WR_REQ SHALL be ignored.
REQ-023 Minimum latency for N words, with mem_ready tied high: start accepted at cycle 0, done at cycle 2N+1.
REQ-024 Overlapping src/dst ranges SHALL be copied in strict ascending word order, with no hazard handling.

Reset
REQ-025 When rst_n=0 at a clock edge: state=IDLE; busy, stall, done, mem_rd, mem_wr = 0; mem_addr, mem_wdata, micro_addr, src_q, dst_q, cnt_q, data_q = 0.
REQ-026 Reset asserted mid-transfer SHALL abort the transfer with no done pulse; the memory request drops on the same edge.

Structure
REQ-027 A shared package SHALL hold the state enum (4 states, 2-bit encoding), the MEMCOPY opcode constant, and MC_UADDR_BASE=6'd32.
REQ-028 The block SHALL be a single module with no sub-modules; micro_addr feeds the existing micro-instruction memory.

Verification
REQ-029 Test: src=0x100, dst=0x200, length=3, mem_ready=1. Required: reads 0x100/0x104/0x108, each followed by a write to 0x200/0x204/0x208 with the matching data; done at cycle 7.
REQ-030 Test: length=0. Required: no mem_rd or mem_wr; done one cycle after start; busy high for 1 cycle.
REQ-031 Test: length=1 with mem_ready held low for 3 cycles in each of RD_REQ and WR_REQ. Required: mem_addr and mem_rd/mem_wr stable while stalled; done at cycle 9.
REQ-032 Test: src=0xFFFFFFFC, length=2. Required: second read goes to 0x00000000.
REQ-033 Test: second start pulse mid-transfer. Required: ignored; the original transfer completes unchanged.
REQ-034 Test: rst_n=0 during WR_REQ of word 2 of 4. Required: next cycle all outputs 0, state IDLE, no done; a new start is then accepted normally.
